// File: rtl/dpram_fifo_ctrl.sv
// dpram_fifo_ctrl
// Controller that turns an external dual-port RAM into a 2**AD deep FIFO.
// Port A of the RAM is written by the FIFO push side and port B is read by
// the pop side; the RAM's port B output is registered, so popped data
// appears on dout one clock after the read is accepted.
//
// Ports
//   clk, rst          : single clock, asynchronous active-high reset
//   wr_en, din        : push request and data; full reports no space
//   rd_en             : pop request; empty reports no data
//   dout, dout_vld    : popped word (straight from ram_dout_b) and its valid
//   count             : occupancy 0..2**AD
//   wr_err, rd_err    : one-clock pulse after a rejected push / pop
//   ram_*             : DPRAM control, address and data pins
//
// Handshake: a push is accepted in a cycle where wr_en=1 and full=0, and a
// pop is accepted where rd_en=1 and empty=0; both are judged on the flags
// as they stand before the clock edge. A request seen while its flag blocks
// it is dropped (no retry) and reported on wr_err / rd_err. dout_vld=1 marks
// the single cycle in which dout carries the word popped one cycle earlier.
module dpram_fifo_ctrl #(
    parameter int WD = 8,
    parameter int AD = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [WD-1:0] din,
    output logic          full,
    input  logic          rd_en,
    output logic [WD-1:0] dout,
    output logic          dout_vld,
    output logic          empty,
    output logic [AD:0]   count,
    output logic          wr_err,
    output logic          rd_err,
    output logic          ram_cs_n,
    output logic          ram_aw_r_n,
    output logic [AD-1:0] ram_addr_a,
    output logic [WD-1:0] ram_din_a,
    output logic          ram_bw_r_n,
    output logic [AD-1:0] ram_addr_b,
    input  logic [WD-1:0] ram_dout_b
);

    localparam logic [AD:0] PTR_ONE = {{AD{1'b0}}, 1'b1};

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    // when the RAM addresses coincide.
    logic [AD:0] wr_ptr;
    logic [AD:0] rd_ptr;
    logic        wr_acc;
    logic        rd_acc;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AD] != rd_ptr[AD]) &&
                   (wr_ptr[AD-1:0] == rd_ptr[AD-1:0]);
    // Modulo 2**(AD+1) difference is exactly the occupancy.
    assign count = wr_ptr - rd_ptr;

    // rst gates the accepts so the RAM sees no write strobe while in reset,
    // even though full reads 0 then.
    assign wr_acc = wr_en && !full && !rst;
    assign rd_acc = rd_en && !empty && !rst;

    assign ram_cs_n   = rst;
    assign ram_aw_r_n = wr_acc;
    assign ram_addr_a = wr_ptr[AD-1:0];
    assign ram_din_a  = din;
    assign ram_bw_r_n = 1'b0;
    assign ram_addr_b = rd_ptr[AD-1:0];
    assign dout       = ram_dout_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            dout_vld <= 1'b0;
            wr_err   <= 1'b0;
            rd_err   <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
            dout_vld <= rd_acc;
            wr_err   <= wr_en && full;
            rd_err   <= rd_en && empty;
        end
    end

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Testbench for dpram_fifo_ctrl (WD=8, AD=4): directed scenarios followed by
// random traffic, compared against a queue-based FIFO model and an external
// DPRAM model.
module tb_dpram_fifo_ctrl;

    localparam int WD    = 8;
    localparam int AD    = 4;
    localparam int DEPTH = 1 << AD;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [WD-1:0] din   = '0;
    logic          full, empty, dout_vld, wr_err, rd_err;
    logic [WD-1:0] dout;
    logic [AD:0]   count;
    logic          ram_cs_n, ram_aw_r_n, ram_bw_r_n;
    logic [AD-1:0] ram_addr_a, ram_addr_b;
    logic [WD-1:0] ram_din_a;
    logic [WD-1:0] ram_dout_b;

    dpram_fifo_ctrl #(.WD(WD), .AD(AD)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .din(din), .full(full),
        .rd_en(rd_en), .dout(dout), .dout_vld(dout_vld),
        .empty(empty), .count(count),
        .wr_err(wr_err), .rd_err(rd_err),
        .ram_cs_n(ram_cs_n), .ram_aw_r_n(ram_aw_r_n),
        .ram_addr_a(ram_addr_a), .ram_din_a(ram_din_a),
        .ram_bw_r_n(ram_bw_r_n), .ram_addr_b(ram_addr_b),
        .ram_dout_b(ram_dout_b)
    );

    // external DPRAM: synchronous write on A, registered read on B
    logic [WD-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (!ram_cs_n && ram_aw_r_n) mem[ram_addr_a] <= ram_din_a;
        ram_dout_b <= mem[ram_addr_b];
    end

    // scoreboard / reference model
    logic [WD-1:0] exp_q[$];
    int            wr_total = 0;  // accepted pushes since reset
    int            rd_total = 0;  // accepted pops since reset
    int            n_chk = 0;
    int            n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock of traffic. Called at posedge+1; returns at next posedge+1.
    task automatic cycle(input bit w, input bit r, input logic [WD-1:0] d);
        bit            m_full, m_empty, w_ok, r_ok;
        logic [WD-1:0] popped;
        wr_en = w;
        rd_en = r;
        din   = d;
        m_full  = (exp_q.size() == DEPTH);
        m_empty = (exp_q.size() == 0);
        w_ok    = w && !m_full;
        r_ok    = r && !m_empty;
        popped  = '0;
        #1;
        check("ram_aw_r_n", 32'(ram_aw_r_n), 32'(w_ok));
        check("ram_addr_a", 32'(ram_addr_a), 32'(wr_total % DEPTH));
        check("ram_addr_b", 32'(ram_addr_b), 32'(rd_total % DEPTH));
        if (w_ok) check("ram_din_a", 32'(ram_din_a), 32'(d));
        check("ram_cs_n", 32'(ram_cs_n), 32'd0);
        check("ram_bw_r_n", 32'(ram_bw_r_n), 32'd0);
        @(posedge clk);
        #1;
        if (r_ok) begin
            popped = exp_q.pop_front();
            rd_total++;
        end
        if (w_ok) begin
            exp_q.push_back(d);
            wr_total++;
        end
        check("count", 32'(count), 32'(exp_q.size()));
        check("empty", 32'(empty), 32'(exp_q.size() == 0));
        check("full", 32'(full), 32'(exp_q.size() == DEPTH));
        check("dout_vld", 32'(dout_vld), 32'(r_ok));
        check("wr_err", 32'(wr_err), 32'(w && m_full));
        check("rd_err", 32'(rd_err), 32'(r && m_empty));
        if (r_ok) check("dout", 32'(dout), 32'(popped));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_empty"}, 32'(empty), 32'd1);
        check({tag, "_full"}, 32'(full), 32'd0);
        check({tag, "_count"}, 32'(count), 32'd0);
        check({tag, "_cs_n"}, 32'(ram_cs_n), 32'd1);
        check({tag, "_aw_r_n"}, 32'(ram_aw_r_n), 32'd0);
        check({tag, "_dout_vld"}, 32'(dout_vld), 32'd0);
        check({tag, "_wr_err"}, 32'(wr_err), 32'd0);
        check({tag, "_rd_err"}, 32'(rd_err), 32'd0);
    endtask

    // Asserts rst between edges with a write pending, checks the
    // asynchronous effect, then releases it after one edge.
    task automatic async_reset();
        wr_en = 1'b1;
        rd_en = 1'b1;
        din   = 8'h55;
        #2;
        rst = 1'b1;
        #1;
        check_reset_state("arst");
        exp_q.delete();
        wr_total = 0;
        rd_total = 0;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic fill_to(input int n);
        while (exp_q.size() < n) cycle(1'b1, 1'b0, 8'($urandom_range(0, 255)));
    endtask

    task automatic drain_to(input int n);
        while (exp_q.size() > n) cycle(1'b0, 1'b1, 8'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        #2;
        wr_en = 1'b1;
        #1;
        check_reset_state("por");
        @(posedge clk);
        #1;
        rst   = 1'b0;
        wr_en = 1'b0;

        // fill with A0..AF, then one overflow push, then idle
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 8'(8'hA0 + i));
        cycle(1'b1, 1'b0, 8'hEE);
        cycle(1'b0, 1'b0, 8'h00);

        // drain in order, one underflow pop, then idle
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 8'h00);
        cycle(1'b0, 1'b1, 8'h00);
        cycle(1'b0, 1'b0, 8'h00);

        // steady state at count=5 with simultaneous push/pop, pointers wrap
        fill_to(5);
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, 8'($urandom_range(0, 255)));
        cycle(1'b0, 1'b0, 8'h00);

        // simultaneous push/pop at empty and at full
        drain_to(0);
        cycle(1'b1, 1'b1, 8'hB3);
        cycle(1'b0, 1'b0, 8'h00);
        fill_to(DEPTH);
        cycle(1'b1, 1'b1, 8'h77);
        cycle(1'b0, 1'b0, 8'h00);

        // reset mid-burst at count=9, then reuse
        drain_to(0);
        fill_to(9);
        async_reset();
        cycle(1'b1, 1'b0, 8'hC1);
        cycle(1'b0, 1'b1, 8'h00);
        cycle(1'b0, 1'b0, 8'h00);

        // random traffic: write-heavy, read-heavy, balanced phases
        for (int ph = 0; ph < 3; ph++) begin
            int wp;
            int rp;
            wp = (ph == 0) ? 80 : (ph == 1) ? 25 : 50;
            rp = (ph == 0) ? 25 : (ph == 1) ? 80 : 50;
            for (int i = 0; i < 150; i++)
                cycle(bit'($urandom_range(0, 99) < wp), bit'($urandom_range(0, 99) < rp),
                      8'($urandom_range(0, 255)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
